// File: rtl/bigmul_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : bigmul_stream_ctrl                                          |
// | Description: Streams A/B operands into a big-integer multiplier, starts  |
// |              it, then drains the 2*size-word product. The optional WAIT  |
// |              watchdog is enabled by BIGMUL_CTRL_TIMEOUT_EN.              |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module bigmul_stream_ctrl #(
    parameter int NWORDS         = 64,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_size,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        mul_wr_en,
    output logic        mul_wr_sel,
    output logic [5:0]  mul_wr_addr,
    output logic [63:0] mul_wr_data,
    output logic        mul_start,
    output logic [31:0] mul_size,
    input  logic        mul_busy,
    input  logic        mul_done,
    output logic [6:0]  mul_rd_addr,
    input  logic [63:0] mul_rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        err_size,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    localparam logic [7:0] c_NWORDS = 8'(NWORDS);

    state_t     r_state;
    logic [6:0] r_size;
    logic [6:0] r_idx;
    logic [6:0] r_rd;
    logic [6:0] r_last_idx;
    logic       r_rd_done;
    logic       r_wait_first;

    logic       w_size_ok;
    logic       w_in_hs;
    logic       w_out_hs;
    logic       w_load;
    logic       w_done_ok;

`ifdef BIGMUL_CTRL_TIMEOUT_EN
    localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_wait_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign in_ready    = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign mul_rd_addr = r_rd;

    assign w_size_ok = (cmd_size != 7'd0) && ({1'b0, cmd_size} <= c_NWORDS);
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = out_valid && out_ready;
    // A done seen on the first WAIT cycle may be left over from a previous job
    assign w_done_ok = mul_done && !mul_busy && !r_wait_first;
    assign w_load    = (r_state == S_DRAIN) && !r_rd_done && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_size       <= 7'd0;
            r_idx        <= 7'd0;
            r_rd         <= 7'd0;
            r_last_idx   <= 7'd0;
            r_rd_done    <= 1'b0;
            r_wait_first <= 1'b0;
            mul_wr_en    <= 1'b0;
            mul_wr_sel   <= 1'b0;
            mul_wr_addr  <= 6'd0;
            mul_wr_data  <= 64'd0;
            mul_start    <= 1'b0;
            mul_size     <= 32'd0;
            out_valid    <= 1'b0;
            out_data     <= 64'd0;
            out_last     <= 1'b0;
            err_size     <= 1'b0;
`ifdef BIGMUL_CTRL_TIMEOUT_EN
            r_wait_cnt   <= 32'd0;
            err_timeout  <= 1'b0;
`endif
        end else begin
            mul_wr_en <= 1'b0;
            mul_start <= 1'b0;
            err_size  <= 1'b0;
`ifdef BIGMUL_CTRL_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            if (w_in_hs) begin
                mul_wr_en   <= 1'b1;
                mul_wr_sel  <= (r_state == S_LOAD_B);
                mul_wr_addr <= r_idx[5:0];
                mul_wr_data <= in_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (w_size_ok) begin
                            r_size     <= cmd_size;
                            mul_size   <= 32'(cmd_size);
                            r_last_idx <= (cmd_size << 1) - 7'd1;
                            r_idx      <= 7'd0;
                            r_state    <= S_LOAD_A;
                        end else begin
                            err_size <= 1'b1;
                        end
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (w_in_hs) begin
                        if (r_idx == r_size - 7'd1) begin
                            r_idx <= 7'd0;
                            if (r_state == S_LOAD_A) begin
                                r_state <= S_LOAD_B;
                            end else begin
                                r_state   <= S_START;
                                mul_start <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 7'd1;
                        end
                    end
                end
                S_START: begin
                    r_state      <= S_WAIT;
                    r_wait_first <= 1'b1;
`ifdef BIGMUL_CTRL_TIMEOUT_EN
                    r_wait_cnt   <= 32'd0;
`endif
                end
                S_WAIT: begin
                    r_wait_first <= 1'b0;
                    if (w_done_ok) begin
                        r_state   <= S_DRAIN;
                        r_rd      <= 7'd0;
                        r_rd_done <= 1'b0;
                    end
`ifdef BIGMUL_CTRL_TIMEOUT_EN
                    else if (r_wait_cnt == c_TMO_LAST) begin
                        err_timeout <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (w_load) begin
                        out_valid <= 1'b1;
                        out_data  <= mul_rd_data;
                        out_last  <= (r_rd == r_last_idx);
                        if (r_rd == r_last_idx) begin
                            r_rd_done <= 1'b1;
                        end else begin
                            r_rd <= r_rd + 7'd1;
                        end
                    end else if (w_out_hs) begin
                        out_valid <= 1'b0;
                    end
                    if (w_out_hs && out_last) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bigmul_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_bigmul_stream_ctrl                                       |
// | Description: Directed bench for bigmul_stream_ctrl with a small          |
// |              multiplier model; BIGMUL_CTRL_TIMEOUT_EN adds the watchdog. |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_bigmul_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_size = 7'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'd0;
    logic        mul_wr_en;
    logic        mul_wr_sel;
    logic [5:0]  mul_wr_addr;
    logic [63:0] mul_wr_data;
    logic        mul_start;
    logic [31:0] mul_size;
    logic        mul_busy = 1'b0;
    logic        mul_done = 1'b0;
    logic [6:0]  mul_rd_addr;
    logic [63:0] mul_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;
    logic        err_size;
    logic        err_timeout;

    always #5 clk = ~clk;

    bigmul_stream_ctrl #(.NWORDS(64), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_size(cmd_size),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mul_wr_en(mul_wr_en), .mul_wr_sel(mul_wr_sel),
        .mul_wr_addr(mul_wr_addr), .mul_wr_data(mul_wr_data),
        .mul_start(mul_start), .mul_size(mul_size),
        .mul_busy(mul_busy), .mul_done(mul_done),
        .mul_rd_addr(mul_rd_addr), .mul_rd_data(mul_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_size(err_size), .err_timeout(err_timeout)
    );

    logic [63:0] res_mem [0:127];
    assign mul_rd_data = res_mem[mul_rd_addr];

    logic [63:0] cap_a [0:63];
    logic [63:0] cap_b [0:63];
    logic [63:0] got_data [0:255];
    logic        got_last [0:255];

    int n_checks = 0;
    int n_errors = 0;
    int n_got = 0, n_wr = 0, n_start = 0, n_errsz = 0, n_errto = 0;
    int n_early = 0, n_ov = 0, n_unstable = 0;
    int cnt = 0, stale_stage = 0;
    bit done_since = 1'b1;
    bit stall_prev = 1'b0;
    logic [63:0] prev_data = 64'd0;
    logic        prev_last = 1'b0;
    bit stale_mode = 1'b0, hang_mode = 1'b0, tog = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Multiplier model and output monitor share one process so they never race
    always @(negedge clk) begin
        if (rst) begin
            mul_busy = 1'b0; mul_done = 1'b0; cnt = 0; stale_stage = 0;
        end else if (mul_start) begin
            n_start++;
            done_since = 1'b0;
            mul_done   = 1'b0;
            if (hang_mode) begin
                mul_busy = 1'b1; cnt = 0;
            end else if (stale_mode) begin
                mul_busy = 1'b0; stale_stage = 1;
            end else begin
                mul_busy = 1'b1; cnt = 3;
            end
        end else if (stale_stage == 1) begin
            mul_done = 1'b1; mul_busy = 1'b0; stale_stage = 2;
        end else if (stale_stage == 2) begin
            mul_done = 1'b0; mul_busy = 1'b1; cnt = 3; stale_stage = 0;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                mul_busy = 1'b0; mul_done = 1'b1; done_since = 1'b1;
            end
        end else begin
            mul_done = 1'b0;
        end

        if (mul_wr_en) begin
            n_wr++;
            if (mul_wr_sel) cap_b[mul_wr_addr] = mul_wr_data;
            else            cap_a[mul_wr_addr] = mul_wr_data;
        end
        if (err_size)    n_errsz++;
        if (err_timeout) n_errto++;
        if (out_valid) n_ov++;
        if (out_valid && !done_since) n_early++;
        if (stall_prev && (!out_valid || out_data !== prev_data || out_last !== prev_last))
            n_unstable++;
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (out_valid && out_ready) begin
            got_data[n_got] = out_data;
            got_last[n_got] = out_last;
            n_got++;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = tog ? ~out_ready : 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_cmd(input logic [6:0] s);
        cmd_valid = 1'b1;
        cmd_size  = s;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] d);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        chk("in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int k = 0;
        while (n_got < target && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("out_count", 64'(n_got), 64'(target));
    endtask

    task automatic run_small(input string tag);
        int b_got;
        res_mem[0] = 64'd15;
        res_mem[1] = 64'd0;
        b_got = n_got;
        send_cmd(7'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_mul_size"}, 64'(mul_size), 64'd1);
        send_word(64'd3);
        send_word(64'd5);
        wait_out(b_got + 2);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_ov_after"}, 64'(out_valid), 64'd0);
        chk({tag, "_w0"}, got_data[b_got], 64'd15);
        chk({tag, "_w1"}, got_data[b_got+1], 64'd0);
        chk({tag, "_l0"}, 64'(got_last[b_got]), 64'd0);
        chk({tag, "_l1"}, 64'(got_last[b_got+1]), 64'd1);
        chk({tag, "_a0"}, cap_a[0], 64'd3);
        chk({tag, "_b0"}, cap_b[0], 64'd5);
    endtask

    initial begin
        int b_got, b_wr, b_st, b_es, b_early, b_ov;
        repeat (3) step();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_mul_size", 64'(mul_size), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_wr_en", 64'(mul_wr_en), 64'd0);
        chk("rst_start", 64'(mul_start), 64'd0);
        chk("rst_err_size", 64'(err_size), 64'd0);
        rst = 1'b0;

        // size 1, out_ready held high
        b_wr = n_wr; b_st = n_start;
        run_small("t1");
        chk("t1_wr_count", 64'(n_wr - b_wr), 64'd2);
        chk("t1_start_count", 64'(n_start - b_st), 64'd1);

        // size 2, carry into the second word, out_ready toggling
        res_mem[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        res_mem[1] = 64'd1;
        res_mem[2] = 64'd0;
        res_mem[3] = 64'd0;
        tog = 1'b1;
        b_got = n_got;
        send_cmd(7'd2);
        send_word(64'hFFFF_FFFF_FFFF_FFFF);
        send_word(64'd0);
        send_word(64'd2);
        send_word(64'd0);
        wait_out(b_got + 4);
        tog = 1'b0;
        repeat (5) step();
        chk("t2_exact4", 64'(n_got - b_got), 64'd4);
        chk("t2_w0", got_data[b_got],   64'hFFFF_FFFF_FFFF_FFFE);
        chk("t2_w1", got_data[b_got+1], 64'd1);
        chk("t2_w2", got_data[b_got+2], 64'd0);
        chk("t2_w3", got_data[b_got+3], 64'd0);
        chk("t2_lasts", {60'd0, got_last[b_got+3], got_last[b_got+2],
                         got_last[b_got+1], got_last[b_got]}, 64'b1000);
        chk("t2_stable", 64'(n_unstable), 64'd0);
        chk("t2_a0", cap_a[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_b0", cap_b[0], 64'd2);
        chk("t2_b1", cap_b[1], 64'd0);

        // rejected sizes
        b_es = n_errsz; b_st = n_start;
        cmd_valid = 1'b1; cmd_size = 7'd0;
        step();
        cmd_valid = 1'b0;
        chk("t3_err0", 64'(err_size), 64'd1);
        chk("t3_ready0", 64'(cmd_ready), 64'd1);
        step();
        chk("t3_err0_clear", 64'(err_size), 64'd0);
        cmd_valid = 1'b1; cmd_size = 7'd65;
        step();
        cmd_valid = 1'b0;
        chk("t3_err65", 64'(err_size), 64'd1);
        chk("t3_ready65", 64'(cmd_ready), 64'd1);
        step();
        chk("t3_pulses", 64'(n_errsz - b_es), 64'd2);
        chk("t3_no_start", 64'(n_start - b_st), 64'd0);

        // largest size is accepted, then abandoned by reset
        send_cmd(7'd64);
        chk("t4_busy64", 64'(busy), 64'd1);
        chk("t4_size64", 64'(mul_size), 64'd64);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // reset after the third B write of a size-4 job
        b_st = n_start; b_wr = n_wr;
        send_cmd(7'd4);
        for (int i = 0; i < 4; i++) send_word(64'(10 + i));
        for (int i = 0; i < 3; i++) send_word(64'(20 + i));
        rst = 1'b1;
        step();
        chk("t5_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_mul_size", 64'(mul_size), 64'd0);
        chk("t5_wr_en", 64'(mul_wr_en), 64'd0);
        rst = 1'b0;
        b_ov = n_ov;
        run_small("t5r");
        chk("t5_wr_count", 64'(n_wr - b_wr), 64'd9);
        chk("t5_start_count", 64'(n_start - b_st), 64'd1);

        // stale done during the first WAIT cycle
        stale_mode = 1'b1;
        b_early = n_early;
        run_small("t6");
        stale_mode = 1'b0;
        chk("t6_no_early_drain", 64'(n_early - b_early), 64'd0);

`ifdef BIGMUL_CTRL_TIMEOUT_EN
        hang_mode = 1'b1;
        b_ov = n_ov;
        send_cmd(7'd1);
        send_word(64'd3);
        send_word(64'd5);
        repeat (16) step();
        chk("t7_no_err_yet", 64'(err_timeout), 64'd0);
        chk("t7_busy_wait", 64'(busy), 64'd1);
        step();
        chk("t7_err", 64'(err_timeout), 64'd1);
        chk("t7_idle", 64'(busy), 64'd0);
        step();
        chk("t7_err_pulse", 64'(err_timeout), 64'd0);
        chk("t7_no_out", 64'(n_ov - b_ov), 64'd0);
        chk("to_pulses", 64'(n_errto), 64'd1);
`else
        chk("to_pulses", 64'(n_errto), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bigmul_stream_ctrl.md
BIGMUL_STREAM_CTRL -- requirements
Module: bigmul_stream_ctrl

Interface
REQ-001 SHALL have parameter NWORDS, default 64: maximum operand size in 64-bit dwords.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65536: WAIT watchdog limit, used only under BIGMUL_CTRL_TIMEOUT_EN.
REQ-003 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1 / cmd_ready  out  1 / cmd_size  in  7  command handshake; operand size in dwords.
- in_valid  in  1 / in_ready  out  1 / in_data  in  64  operand stream, A words 0..size-1 then B words 0..size-1.
- mul_wr_en  out  1 / mul_wr_sel  out  1 (0=A, 1=B) / mul_wr_addr  out  6 / mul_wr_data  out  64  multiplier operand cache write port.
- mul_start  out  1 / mul_size  out  32 / mul_busy  in  1 / mul_done  in  1  multiplier control.
- mul_rd_addr  out  7 / mul_rd_data  in  64  result cache read port, combinational read.
- out_valid  out  1 / out_ready  in  1 / out_data  out  64 / out_last  out  1  result stream.
- busy  out  1  high whenever state is not IDLE.
- err_size  out  1  one-cycle pulse when a command is rejected.
- err_timeout  out  1  one-cycle pulse when the watchdog expires.

Function
REQ-004 SHALL implement FSM IDLE -> LOAD_A -> LOAD_B -> START -> WAIT -> DRAIN -> IDLE.
REQ-005 IDLE: cmd_ready=1; on cmd_valid with 1<=cmd_size<=NWORDS SHALL latch size, drive mul_size=size (held until the next accepted command), and enter LOAD_A.
REQ-006 IDLE: cmd_size=0 or cmd_size>NWORDS SHALL pulse err_size for one cycle and remain in IDLE.
REQ-007 LOAD_A/LOAD_B: in_ready=1, other states in_ready=0.
REQ-008 Each in_valid&&in_ready SHALL produce, on the next cycle, mul_wr_en=1 for exactly one cycle, with wr_sel=state (0=A, 1=B), wr_addr=word index and wr_data=in_data; otherwise mul_wr_en=0.
REQ-009 The word index SHALL reset to 0 on entry to each load state; the handshake at index size-1 SHALL move LOAD_A->LOAD_B or LOAD_B->START.
REQ-010 START SHALL assert mul_start for exactly one cycle (the final B write lands the same cycle), then enter WAIT.
REQ-011 WAIT SHALL ignore mul_done on its first cycle and exit to DRAIN on the first later cycle with mul_done=1 and mul_busy=0.
REQ-012 DRAIN SHALL emit 2*size words at addresses 0..2*size-1 in ascending order.
REQ-013 out_data and out_valid SHALL be registered: mul_rd_addr points at the next word; that word is loaded when the output register is empty or being consumed (out_valid&&out_ready) in the same cycle, giving back-to-back throughput of one word per cycle.
REQ-014 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-015 out_last SHALL be 1 only with word 2*size-1; that handshake SHALL return to IDLE with out_valid=0 on the next cycle.
REQ-016 A new command SHALL NOT be accepted before the return to IDLE.
REQ-017 Word and read counters SHALL be 7 bits wide; there SHALL be no wrap beyond 2*NWORDS-1.

Reset
REQ-018 On rst=1 at a posedge: state=IDLE; counters=0; mul_size=0; all outputs 0 except cmd_ready=1.
REQ-019 Reset mid-operation SHALL abandon the transfer with no further mul_wr_en, mul_start or out_valid.
REQ-020 After reset is released, the block SHALL accept a command on the first cycle.

Configuration
REQ-021 With BIGMUL_CTRL_TIMEOUT_EN defined, a WAIT cycle counter SHALL pulse err_timeout and return to IDLE with no drain if TIMEOUT_CYCLES cycles elapse in WAIT without a qualifying mul_done.
REQ-022 Without BIGMUL_CTRL_TIMEOUT_EN, WAIT SHALL wait indefinitely and err_timeout SHALL be tied to 0.

Verification
REQ-023 size=1, A0=3, B0=5, multiplier model returns {15,0}, out_ready=1 -> out_data 15 then 0, out_last on the 2nd word, busy drops the cycle after.
REQ-024 size=2, A={FFFF_FFFF_FFFF_FFFF,0}, B={2,0}, out_ready toggling 1/0 -> exactly 4 words FFFF_FFFF_FFFF_FFFE, 1, 0, 0, stable during stalls.
REQ-025 cmd_size=0, then cmd_size=65 -> err_size pulses twice, mul_start never asserted, cmd_ready stays 1.
REQ-026 rst asserted after the 3rd LOAD_B write with size=4 -> next cycle cmd_ready=1, no mul_start; a following size=1 command completes normally.
REQ-027 With BIGMUL_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, mul_done held 0 -> err_timeout after 16 WAIT cycles, out_valid never asserted.
REQ-028 mul_done stale-high during the first WAIT cycle -> ignored; DRAIN begins only on the later genuine completion.
